// File: rtl/seq_modulus_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock, signed or unsigned.
// Latency WIDTH+2 cycles from accepted start to done (1 cycle for divide-by-zero); start ignored while busy.
module seq_modulus_divider #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     numerator,
  input  logic [WIDTH-1:0]     denominator,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [2*WIDTH-1:0]   modulus,
  output logic                 error
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               sgn_q, sgn_d;
  logic               num_neg_q, num_neg_d;
  logic               den_neg_q, den_neg_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [2*WIDTH-1:0] mod_q, mod_d;
  logic               err_q, err_d;

  logic [WIDTH:0]     shifted;
  logic               fits;
  logic               num_neg_in;
  logic               den_neg_in;
  logic [WIDTH-1:0]   fix_rem;

  function automatic logic [2*WIDTH-1:0] extend(input logic sgn, input logic [WIDTH-1:0] v);
    if (sgn) begin
      return {{WIDTH{v[WIDTH-1]}}, v};
    end
    return {{WIDTH{1'b0}}, v};
  endfunction

  // The dividend register doubles as the quotient: quotient bits enter at the bottom.
  assign shifted    = {rem_q, dvd_q[WIDTH-1]};
  assign fits       = (shifted >= {1'b0, dvs_q});
  assign num_neg_in = signed_mode & numerator[WIDTH-1];
  assign den_neg_in = signed_mode & denominator[WIDTH-1];
  assign fix_rem    = num_neg_q ? -rem_q : rem_q;

  always_comb begin
    state_d   = state_q;
    sgn_d     = sgn_q;
    num_neg_d = num_neg_q;
    den_neg_d = den_neg_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    mod_d     = mod_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sgn_d     = signed_mode;
          num_neg_d = num_neg_in;
          den_neg_d = den_neg_in;
          dvd_d     = num_neg_in ? -numerator : numerator;
          dvs_d     = den_neg_in ? -denominator : denominator;
          rem_d     = '0;
          cnt_d     = '0;
          if (denominator == '0) begin
            quot_d  = '1;
            mod_d   = extend(signed_mode, numerator);
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        // rem < divisor before the shift, so the difference always fits in WIDTH bits.
        rem_d = fits ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], fits};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quot_d  = (num_neg_q ^ den_neg_q) ? -dvd_q : dvd_q;
        mod_d   = extend(sgn_q, fix_rem);
        err_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sgn_q     <= 1'b0;
      num_neg_q <= 1'b0;
      den_neg_q <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quot_q    <= '0;
      mod_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sgn_q     <= sgn_d;
      num_neg_q <= num_neg_d;
      den_neg_q <= den_neg_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      quot_q    <= quot_d;
      mod_q     <= mod_d;
      err_q     <= err_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign quotient = quot_q;
  assign modulus  = mod_q;
  assign error    = err_q;

endmodule

// File: tb/tb_seq_modulus_divider.sv
// Randomised and directed bench for seq_modulus_divider against a cycle-level arithmetic model.
module tb_seq_modulus_divider;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   numerator = '0;
  logic [W-1:0]   denominator = '0;
  logic           busy;
  logic           done;
  logic [W-1:0]   quotient;
  logic [2*W-1:0] modulus;
  logic           error;

  int n_chk = 0;
  int n_fail = 0;

  seq_modulus_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .numerator(numerator), .denominator(denominator),
    .busy(busy), .done(done), .quotient(quotient), .modulus(modulus), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]   q;
    logic [2*W-1:0] m;
    logic           e;
  } res_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result as the language's own / and % define it.
  function automatic res_t ref_div(input logic sm, input logic [W-1:0] n, input logic [W-1:0] d);
    res_t r;
    int sn, sd, iq, ir;
    if (d == '0) begin
      r.q = '1;
      r.m = sm ? {{W{n[W-1]}}, n} : {{W{1'b0}}, n};
      r.e = 1'b1;
    end else if (!sm) begin
      r.q = n / d;
      r.m = {{W{1'b0}}, n % d};
      r.e = 1'b0;
    end else begin
      sn = int'($signed(n));
      sd = int'($signed(d));
      iq = sn / sd;
      ir = sn % sd;
      r.q = 16'(iq);
      r.m = 32'(ir);
      r.e = 1'b0;
    end
    return r;
  endfunction

  // m_left counts remaining busy cycles; 1 means this is the done cycle.
  int   m_left = 0;
  res_t m_out = '0;
  res_t m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_out  <= '0;
      m_pend <= '0;
    end else if (m_left == 0) begin
      if (start) begin
        if (denominator == '0) begin
          m_left <= 1;
          m_out  <= ref_div(signed_mode, numerator, denominator);
        end else begin
          m_left <= W + 2;
          m_pend <= ref_div(signed_mode, numerator, denominator);
        end
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) m_out <= m_pend;
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_left > 0));
    chk("done", 64'(done), 64'(m_left == 1));
    chk("quotient", 64'(quotient), 64'(m_out.q));
    chk("modulus", 64'(modulus), 64'(m_out.m));
    chk("error", 64'(error), 64'(m_out.e));
  end

  task automatic do_op(input logic sm, input logic [W-1:0] n, input logic [W-1:0] d,
                       output int lat, output int bcnt);
    @(negedge clk);
    signed_mode = sm;
    numerator   = n;
    denominator = d;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    numerator   = 16'($urandom);
    denominator = 16'($urandom);
    signed_mode = 1'($urandom);
    lat  = 1;
    bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (busy) bcnt++;
    if (lat >= 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done", lat);
    end
  endtask

  task automatic chk_res(input string name, input logic [W-1:0] q, input logic [2*W-1:0] m,
                         input logic e);
    chk({name, "_q"}, 64'(quotient), 64'(q));
    chk({name, "_mod"}, 64'(modulus), 64'(m));
    chk({name, "_err"}, 64'(error), 64'(e));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0001;
      4: return 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int lat, bcnt, ndone, d1, d2;
    logic [W-1:0] q1, q2;
    logic [2*W-1:0] m1;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk_res("reset", 16'h0000, 32'h0, 1'b0);
    #2 rst_n = 1'b1;

    do_op(1'b0, 16'd15, 16'd2, lat, bcnt);
    chk("u15_2_latency", 64'(lat), 64'd18);
    chk("u15_2_busy_cycles", 64'(bcnt), 64'd18);
    chk_res("u15_2", 16'd7, 32'h00000001, 1'b0);

    do_op(1'b0, 16'd15, 16'd0, lat, bcnt);
    chk("div0_latency", 64'(lat), 64'd1);
    chk_res("div0", 16'hFFFF, 32'h0000000F, 1'b1);

    do_op(1'b0, 16'd100, 16'd7, lat, bcnt);
    chk_res("u100_7", 16'd14, 32'h00000002, 1'b0);

    do_op(1'b1, 16'hFFF9, 16'h0002, lat, bcnt);
    chk_res("s_m7_2", 16'hFFFD, 32'hFFFFFFFF, 1'b0);

    do_op(1'b1, 16'h0007, 16'hFFFE, lat, bcnt);
    chk_res("s_7_m2", 16'hFFFD, 32'h00000001, 1'b0);

    do_op(1'b1, 16'h8000, 16'hFFFF, lat, bcnt);
    chk_res("s_ovf", 16'h8000, 32'h00000000, 1'b0);

    do_op(1'b0, 16'hFFFF, 16'h0001, lat, bcnt);
    chk_res("u_ffff_1", 16'hFFFF, 32'h00000000, 1'b0);

    // start held for 30 edges, operands swapped in cycle 5
    @(negedge clk);
    signed_mode = 1'b0;
    numerator   = 16'd1000;
    denominator = 16'd3;
    start       = 1'b1;
    ndone = 0; d1 = 0; d2 = 0; q1 = '0; q2 = '0; m1 = '0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin d1 = c; q1 = quotient; m1 = modulus; end
        if (ndone == 2) begin d2 = c; q2 = quotient; end
      end
      if (c == 5) begin numerator = 16'd50; denominator = 16'd5; end
      if (c == 30) start = 1'b0;
    end
    chk("hs_done_count", 64'(ndone), 64'd2);
    chk("hs_first_done_cycle", 64'(d1), 64'd18);
    chk("hs_first_q", 64'(q1), 64'd333);
    chk("hs_first_mod", 64'(m1), 64'd1);
    chk("hs_second_done_cycle", 64'(d2), 64'd37);
    chk("hs_second_q", 64'(q2), 64'd10);

    // reset in cycle 8 of an operation
    @(negedge clk);
    signed_mode = 1'b0; numerator = 16'd999; denominator = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk_res("abort", 16'h0000, 32'h0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    do_op(1'b0, 16'd1000, 16'd7, lat, bcnt);
    chk("post_reset_latency", 64'(lat), 64'd18);
    chk_res("post_reset", 16'd142, 32'h00000006, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start       = ($urandom_range(0, 2) == 0);
      signed_mode = 1'($urandom);
      numerator   = pick();
      denominator = pick();
    end
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_modulus_divider.md
# seq_modulus_divider

Parametrised, multi-cycle integer divider that returns quotient and remainder (modulus) of two WIDTH-bit operands, in unsigned or signed (two's-complement) mode, with a start/busy/done handshake and divide-by-zero flag. It replaces the single-cycle behavioural modulus in the arithmetic section of the datapath. It uses a restoring shift-subtract core, one quotient bit per clock, so wide operands do not need a combinational divider. The remainder is presented zero- or sign-extended to 2*WIDTH bits, matching the datapath's double-width result bus.

## Interface
- WIDTH, 16, operand, quotient and core remainder width (>= 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; accepted only in IDLE
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- numerator  input  WIDTH  dividend; sampled with start
- denominator  input  WIDTH  divisor; sampled with start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  registered quotient
- modulus  output  2*WIDTH  registered remainder, extended per mode
- error  output  1  registered divide-by-zero flag for the last operation

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 latches signed_mode, numerator and denominator.
  - In signed mode, also latches the magnitudes and signs of both operands.
  - denominator==0 -> DONE. All other cases -> CALC, with the iteration counter at 0.
- CALC runs WIDTH iterations, one per cycle.
  - Shift {rem, dividend} left by 1.
  - If rem >= divisor magnitude, subtract and set the quotient bit to 1.
  - After iteration WIDTH-1 -> FIX.
- FIX (one cycle):
  - Signed mode: the quotient is negated if the operand signs differ; the remainder is negated if the numerator is negative.
  - The quotient truncates toward zero and the remainder takes the sign of the numerator, as Verilog % and / do.
  - The result is written to the output registers, then -> DONE.
- DONE: done=1 for one cycle, then -> IDLE unconditionally.
- Divide by zero:
  - error=1, quotient = all ones.
  - modulus = numerator, extended per mode.
  - Outputs are written on the transition into DONE.
- Normal completion clears error to 0.
- Extension rule:
  - Unsigned: modulus[2*WIDTH-1:WIDTH] = 0.
  - Signed: every upper bit = remainder[WIDTH-1].
- Signed overflow: most-negative / -1 gives quotient = most-negative (wraps), modulus = 0, error = 0.
- Unsigned numerator < denominator gives quotient 0 and modulus = numerator.
- start while busy=1, including the DONE cycle, is ignored and not queued.
- Operand and mode changes after acceptance have no effect on the running operation.
- quotient, modulus and error hold their values until the next operation reaches DONE.

## Timing
- Reset, asynchronous: state = IDLE, busy=0, done=0, quotient=0, modulus=0, error=0, counter and internal registers = 0.
- Reset mid-operation aborts immediately. No done pulse; outputs read 0.
- Cycle numbering: start accepted at rising edge 0.
- Normal path:
  - CALC occupies cycles 1..WIDTH and FIX occupies cycle WIDTH+1.
  - done=1 and outputs valid in cycle WIDTH+2, i.e. WIDTH+2 cycles of latency.
- Divide-by-zero path: done=1 and outputs valid in cycle 1.
- busy rises in cycle 1 and falls in the cycle after done.
- Earliest next accepted start: the first IDLE cycle after done, giving WIDTH+3 cycles throughput per operation.
- All outputs are registered; none depend combinationally on the inputs.

## Test plan
- WIDTH=16, unsigned 15 / 2 -> quotient=7, modulus=32'h00000001, error=0, done exactly in cycle 18, busy high cycles 1..18.
- Unsigned 15 / 0 -> error=1, quotient=16'hFFFF, modulus=32'h0000000F, done in cycle 1; a following 100 / 7 -> quotient=14, modulus=2, error=0.
- Signed -7 / 2 (16'hFFF9, 16'h0002) -> quotient=16'hFFFD, modulus=32'hFFFFFFFF; signed 7 / -2 -> quotient=16'hFFFD, modulus=32'h00000001.
- Signed 16'h8000 / 16'hFFFF -> quotient=16'h8000, modulus=0, error=0; unsigned 16'hFFFF / 16'h0001 -> quotient=16'hFFFF, modulus=0.
- Handshake: start held high for 30 cycles with operands changed in cycle 5 -> only the first operands are used, one done per accepted start, and the second start is accepted in cycle 19.
- rst_n pulsed low in cycle 8 of an operation -> busy, done and outputs go to 0 at once, with no done pulse; a new start after release completes in WIDTH+2 cycles.
